inst_loader: RTL and testbench

Receives a program image byte-by-byte from the UART receiver and writes it into instruction memory. It then returns a 0xAA acknowledge byte through the UART transmitter and raises a sticky `done`. The block sits between `uart_rx`/`uart_tx` and the instruction BRAM read by `fetch`. It is active only while the core is in LOAD mode; when `done` is high, the core switches to EXEC.

---
 rtl/constant.sv | 19 +
 rtl/inst_loader.sv | 152 +++++++++++++++
 tb/tb_inst_loader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/constant.sv
// Shared loader constants: memory geometry, acknowledge byte and FSM state encoding.
// No logic; imported by the instruction loader.
// Keep INST_SIZE in step with the instruction BRAM depth used by fetch.
package constant;

  localparam int         INST_SIZE = 15;
  localparam logic [7:0] ACK_BYTE  = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_ACK,
    S_WAIT_TX,
    S_DONE,
    S_ERR
  } ld_state_t;

endpackage

// File: rtl/inst_loader.sv
// Loads a big-endian program image (32-bit word count, then words) from the UART into instruction memory.
// Latency: write strobe one cycle after the 4th byte of each word; ack requested the cycle after the last write.
// Backpressure: none on rx (bytes are single-cycle pulses); the ack waits in ACK while tx_busy is high.
module inst_loader #(
  parameter int INST_SIZE = constant::INST_SIZE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load_en,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  input  logic                 ferr,
  output logic                 we,
  output logic [INST_SIZE-1:0] waddr,
  output logic [31:0]          wdata,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 done,
  output logic                 err
);
  import constant::*;

  // Largest legal word count: the whole memory.
  localparam logic [31:0] CAPACITY = 32'd1 << INST_SIZE;

  ld_state_t r_state;
  ld_state_t w_next;

  logic [1:0]           r_bcnt;
  logic [23:0]          r_sr;
  logic [31:0]          r_wcnt;
  logic [31:0]          r_n;
  logic                 r_we;
  logic [INST_SIZE-1:0] r_waddr;
  logic [31:0]          r_wdata;
  logic                 r_tx_start;
  logic                 r_seen_busy;
  logic [2:0]           r_txcnt;

  logic                 w_in_load;
  logic                 w_acc;
  logic                 w_last;
  logic [31:0]          w_word;
  logic [31:0]          w_wcnt_inc;

  // Byte acceptance and word assembly; a load_en drop wins over a same-cycle byte.
  always_comb begin
    w_in_load  = (r_state == S_LEN) || (r_state == S_DATA);
    w_acc      = w_in_load && load_en && rx_ready && !ferr;
    w_last     = w_acc && (r_bcnt == 2'd3);
    w_word     = {r_sr, rx_data};
    w_wcnt_inc = r_wcnt + 32'd1;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_en) w_next = S_LEN;
      end
      S_LEN: begin
        if (!load_en)               w_next = S_IDLE;
        else if (rx_ready && ferr)  w_next = S_ERR;
        else if (w_last) begin
          if (w_word == 32'd0)      w_next = S_ACK;
          else if (w_word > CAPACITY) w_next = S_ERR;
          else                      w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (!load_en)                          w_next = S_IDLE;
        else if (rx_ready && ferr)             w_next = S_ERR;
        else if (w_last && (w_wcnt_inc == r_n)) w_next = S_ACK;
      end
      S_ACK: begin
        if (!tx_busy) w_next = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // Finish once the transmitter has risen and fallen, or if it never reacted.
        if (!tx_busy && (r_seen_busy || (r_txcnt == 3'd4))) w_next = S_DONE;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Counters, shift register, write port and ack request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bcnt      <= '0;
      r_sr        <= '0;
      r_wcnt      <= '0;
      r_n         <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_tx_start  <= 1'b0;
      r_seen_busy <= 1'b0;
      r_txcnt     <= '0;
    end else begin
      r_we       <= 1'b0;
      r_tx_start <= 1'b0;

      if (r_state == S_IDLE) begin
        r_bcnt <= '0;
        r_wcnt <= '0;
        r_sr   <= '0;
      end

      if (w_acc) begin
        r_sr   <= w_word[23:0];
        r_bcnt <= r_bcnt + 2'd1;
        if (w_last && (r_state == S_LEN)) r_n <= w_word;
        if (w_last && (r_state == S_DATA)) begin
          r_we    <= 1'b1;
          r_waddr <= r_wcnt[INST_SIZE-1:0];
          r_wdata <= w_word;
          r_wcnt  <= w_wcnt_inc;
        end
      end

      if ((r_state == S_ACK) && !tx_busy) begin
        r_tx_start  <= 1'b1;
        r_seen_busy <= 1'b0;
        r_txcnt     <= '0;
      end

      if (r_state == S_WAIT_TX) begin
        if (tx_busy)            r_seen_busy <= 1'b1;
        if (r_txcnt != 3'd4)    r_txcnt     <= r_txcnt + 3'd1;
      end
    end
  end

  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign tx_start = r_tx_start;
  assign tx_data  = ACK_BYTE;
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: write scoreboard, uart_tx stand-in, scenario tasks.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Every wait is bounded; a stuck run is caught by the watchdog.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        ferr = 1'b0;
  logic        hold_busy = 1'b0;
  logic        we;
  logic [14:0] waddr;
  logic [31:0] wdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int model_cnt = 0;

  typedef struct {
    logic [14:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  assign tx_busy = hold_busy | (model_cnt != 0);

  inst_loader dut (
    .clk      (clk),
    .rstn     (rstn),
    .load_en  (load_en),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .ferr     (ferr),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in (busy for 3 cycles after a start) plus write scoreboard.
  always @(negedge clk) begin
    if (model_cnt > 0) model_cnt = model_cnt - 1;
    if (tx_start === 1'b1) begin
      model_cnt = 3;
      ack_cnt   = ack_cnt + 1;
      checks++;
      if (tx_data !== 8'hAA) begin
        errors++;
        $display("FAIL ack_byte: got %02h want aa", tx_data);
      end
    end
    if (we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %08h, none expected", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (waddr !== e.a || wdata !== e.d) begin
          errors++;
          $display("FAIL write: got %0h=%08h want %0h=%08h", waddr, wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(posedge clk); #1;
    rx_data = b; rx_ready = 1'b1; ferr = fe;
    @(posedge clk); #1;
    rx_ready = 1'b0; ferr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic expect_write(input logic [14:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rstn = 1'b0; load_en = 1'b0; hold_busy = 1'b0; rx_ready = 1'b0; ferr = 1'b0;
    tick(2);
    exp_q.delete();
    model_cnt = 0;
    ack_cnt = 0;
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b want 1", name, done);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (we !== 1'b0 || waddr !== 15'd0 || wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_wport: we=%b waddr=%0h wdata=%08h want 0/0/0", we, waddr, wdata);
    end
    checks++;
    if (tx_data !== 8'hAA) begin
      errors++;
      $display("FAIL reset_txdata: got %02h want aa", tx_data);
    end
    check_bit("reset_txstart", tx_start, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_err", err, 1'b0);
  endtask

  task automatic test_two_words();
    do_reset();
    load_en = 1'b1; tick(1);
    send_word(32'd2);
    expect_write(15'd0, 32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    expect_write(15'd1, 32'h01234567);
    send_word(32'h01234567);
    wait_done("two_words");
    check_bit("two_words_err", err, 1'b0);
    check_int("two_words_acks", ack_cnt, 1);
    check_int("two_words_pending", exp_q.size(), 0);
  endtask

  task automatic test_zero_len();
    do_reset();
    load_en = 1'b1; tick(1);
    send_word(32'd0);
    wait_done("zero_len");
    check_int("zero_len_acks", ack_cnt, 1);
    check_bit("zero_len_err", err, 1'b0);
  endtask

  task automatic test_oversize();
    do_reset();
    load_en = 1'b1; tick(1);
    send_word(32'h00008001);
    tick(10);
    check_bit("oversize_err", err, 1'b1);
    check_bit("oversize_done", done, 1'b0);
    check_int("oversize_acks", ack_cnt, 0);
  endtask

  task automatic test_ferr();
    do_reset();
    load_en = 1'b1; tick(1);
    send_word(32'd1);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b0);
    tick(10);
    check_bit("ferr_err", err, 1'b1);
    check_int("ferr_acks", ack_cnt, 0);
    send_word(32'h12345678);
    tick(5);
    check_bit("ferr_sticky", err, 1'b1);
    check_bit("ferr_no_done", done, 1'b0);
    do_reset();
    check_bit("ferr_cleared_by_reset", err, 1'b0);
  endtask

  task automatic test_load_en_gate();
    do_reset();
    send_word(32'd1);
    send_word(32'h11111111);
    load_en = 1'b1; tick(1);
    send_word(32'd1);
    expect_write(15'd0, 32'h20010005);
    send_word(32'h20010005);
    wait_done("gate");
    check_int("gate_pending", exp_q.size(), 0);
    check_int("gate_acks", ack_cnt, 1);
  endtask

  task automatic test_load_en_drop();
    do_reset();
    load_en = 1'b1; tick(1);
    send_word(32'd2);
    expect_write(15'd0, 32'hAAAA0001);
    send_word(32'hAAAA0001);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    // byte coincident with the load_en fall must be discarded
    @(posedge clk); #1;
    load_en = 1'b0; rx_data = 8'h56; rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    tick(2);
    check_bit("drop_not_done", done, 1'b0);
    load_en = 1'b1; tick(1);
    send_word(32'd1);
    expect_write(15'd0, 32'h0BADF00D);
    send_word(32'h0BADF00D);
    wait_done("drop");
    check_int("drop_pending", exp_q.size(), 0);
  endtask

  task automatic test_busy_hold();
    logic early;
    early = 1'b0;
    do_reset();
    hold_busy = 1'b1;
    load_en = 1'b1; tick(1);
    send_word(32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) early = 1'b1;
    end
    check_bit("busy_no_early_start", early, 1'b0);
    check_bit("busy_not_done", done, 1'b0);
    @(posedge clk); #1;
    hold_busy = 1'b0;
    wait_done("busy");
    check_int("busy_acks", ack_cnt, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_en = 1'b1; tick(1);
    send_word(32'd2);
    expect_write(15'd0, 32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rstn = 1'b0;
    tick(1);
    checks++;
    if (we !== 1'b0 || waddr !== 15'd0 || wdata !== 32'd0 || tx_start !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: we=%b waddr=%0h wdata=%08h txs=%b done=%b err=%b want all 0",
               we, waddr, wdata, tx_start, done, err);
    end
    rstn = 1'b1; tick(1);
    send_word(32'd1);
    expect_write(15'd0, 32'h13572468);
    send_word(32'h13572468);
    wait_done("mid_reset");
    check_int("mid_reset_pending", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_oversize();
    test_ferr();
    test_load_en_gate();
    test_load_en_drop();
    test_busy_hold();
    test_reset_mid();
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
